// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI IDs, burst encoding and bridge FSM state types
package axi_pkg;
  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_e;
endpackage

// File: rtl/axi_wr_ctrl.sv
// axi_wr_ctrl: single-outstanding AXI write engine with independent AW/W handshakes
module axi_wr_ctrl
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        go,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic        idle,
  output logic        done
);
  w_state_e    w_state_q, w_state_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [3:0]  wstrb_q, wstrb_d;
  assign awvalid = (w_state_q == W_REQ) & ~aw_done_q;
  assign wvalid  = (w_state_q == W_REQ) & ~w_done_q;
  assign bready  = w_state_q == W_B;
  assign idle    = w_state_q == W_IDLE;
  assign done    = bvalid & bready;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  // next state: latch request on accept, track AW and W completion separately
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (w_state_q)
      W_IDLE: if (go) begin
        w_state_d = W_REQ;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        awaddr_d  = req_addr;
        awsize_d  = {1'b0, req_size};
        wdata_d   = req_wdata;
        wstrb_d   = req_wstrb;
      end
      W_REQ: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d & w_done_d) w_state_d = W_B;
      end
      W_B: if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end
  // state and latched write fields
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end
endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: arbitrates fetch and data SRAM-like ports onto one AXI3 master
module cpu_axi_bridge
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  r_state_e    r_state_q, r_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [3:0]  arid_q, arid_d;
  logic        data_rd, data_rd_ok, data_wr_ok, inst_ok, w_idle, w_done, r_idle, r_fire;
  logic        unused_ok;
  assign unused_ok = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};
  assign r_idle     = r_state_q == R_IDLE;
  assign data_rd    = data_sram_req & ~data_sram_wr;
  assign data_rd_ok = resetn & data_rd & r_idle & w_idle;
  assign data_wr_ok = resetn & data_sram_req & data_sram_wr & w_idle & ~(~r_idle & (arid_q == ID_DATA));
  assign inst_ok    = resetn & inst_sram_req & r_idle & ~data_rd;
  assign inst_sram_addr_ok = inst_ok;
  assign data_sram_addr_ok = data_rd_ok | data_wr_ok;
  assign arvalid = r_state_q == R_AR;
  assign rready  = r_state_q == R_R;
  assign r_fire  = rvalid & rready;
  assign inst_sram_data_ok = r_fire & (rid == ID_INST);
  assign data_sram_data_ok = (r_fire & (rid == ID_DATA)) | w_done;
  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arlen   = 8'd0;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b0;
  assign arcache = 4'b0;
  assign arprot  = 3'b0;
  assign awid    = ID_DATA;
  assign awlen   = 8'd0;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b0;
  assign awcache = 4'b0;
  assign awprot  = 3'b0;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;
  // read FSM: data wins arbitration, request fields latched on accept
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    arid_d    = arid_q;
    case (r_state_q)
      R_IDLE: if (data_rd_ok | inst_ok) begin
        r_state_d = R_AR;
        araddr_d  = data_rd_ok ? data_sram_addr : inst_sram_addr;
        arsize_d  = {1'b0, data_rd_ok ? data_sram_size : inst_sram_size};
        arid_d    = data_rd_ok ? ID_DATA : ID_INST;
      end
      R_AR: if (arready) r_state_d = R_R;
      R_R: if (rvalid) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end
  // read state and latched AR fields
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arid_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      arid_q    <= arid_d;
    end
  end
  axi_wr_ctrl u_wr (
    .clk       (clk),
    .resetn    (resetn),
    .go        (data_wr_ok),
    .req_addr  (data_sram_addr),
    .req_size  (data_sram_size),
    .req_wstrb (data_sram_wstrb),
    .req_wdata (data_sram_wdata),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready),
    .idle      (w_idle),
    .done      (w_done)
  );
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: randomized requesters and AXI slave checked against a transaction-level model
module tb_cpu_axi_bridge;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_sram_req = 0, inst_sram_wr = 0;
  logic [1:0]  inst_sram_size = 0;
  logic [3:0]  inst_sram_wstrb = 0;
  logic [31:0] inst_sram_addr = 0, inst_sram_wdata = 0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req = 0, data_sram_wr = 0;
  logic [1:0]  data_sram_size = 0;
  logic [3:0]  data_sram_wstrb = 0;
  logic [31:0] data_sram_addr = 0, data_sram_wdata = 0;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, arcache, awcache;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]  wstrb;
  logic        arready = 0, awready = 0, wready = 0;
  logic [3:0]  rid = 0, bid = 0;
  logic [31:0] rdata = 0;
  logic [1:0]  rresp = 0, bresp = 0;
  logic        rlast = 1, rvalid = 0, bvalid = 0;

  int vectors = 0, errors = 0;

  // transaction-level model: one pending request per requester, slave progress flags
  bit          inst_pend, data_pend, data_pend_wr;
  logic [31:0] ip_addr, dp_addr, dp_wdata;
  logic [1:0]  ip_size, dp_size;
  logic [3:0]  dp_wstrb;
  bit          ar_done, r_active, aw_got, w_got, b_active;
  int          r_wait, b_wait;
  bit          rd_busy, wr_busy, e_iok, e_dok, e_arv, e_awv, e_wv, ar_hs, aw_hs, w_hs, r_fire, b_fire;

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5a0000;
  endfunction

  task automatic new_inst();
    inst_sram_req   = $urandom_range(0, 1);
    inst_sram_addr  = $urandom & 32'hffff_fffc;
    inst_sram_size  = 2'($urandom_range(0, 2));
    inst_sram_wstrb = 4'($urandom);
    inst_sram_wdata = $urandom;
  endtask

  task automatic new_data();
    data_sram_req   = $urandom_range(0, 1);
    data_sram_wr    = $urandom_range(0, 1);
    data_sram_addr  = $urandom & 32'hffff_fffc;
    data_sram_size  = 2'($urandom_range(0, 2));
    data_sram_wstrb = 4'($urandom);
    data_sram_wdata = $urandom;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_iaok"}, inst_sram_addr_ok, 0);
    chk({tag, "_daok"}, data_sram_addr_ok, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_idok"}, inst_sram_data_ok, 0);
    chk({tag, "_ddok"}, data_sram_data_ok, 0);
  endtask

  initial begin
    inst_sram_req = 1; data_sram_req = 1; data_sram_wr = 0;
    #2;
    chk_idle_outputs("rst");
    chk("tie_len", {arlen, awlen}, 0);
    chk("tie_burst", {arburst, awburst}, 4'b0101);
    chk("tie_misc", {arlock, arcache, arprot, awlock, awcache, awprot}, 0);
    chk("tie_ids", {awid, wid, 3'b0, wlast}, 12'h111);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1; data_sram_req = 0;
    inst_sram_addr = 32'h1c000000; inst_sram_size = 2;
    @(negedge clk);
    chk("post_rst_iaok", inst_sram_addr_ok, 1);
    @(posedge clk); #1;
    inst_sram_req = 0;
    @(negedge clk);
    chk("r_ar_arvalid", arvalid, 1);
    chk("r_ar_araddr", araddr, 32'h1c000000);
    chk("r_ar_arid", arid, 0);
    #2;
    inst_sram_req = 1; data_sram_req = 1;
    resetn = 0;
    #1;
    chk_idle_outputs("midrst");
    @(posedge clk); @(posedge clk); #1;
    resetn = 1;
    inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2;
    data_sram_req = 0;
    repeat (4000) begin
      @(negedge clk);
      rd_busy = inst_pend | (data_pend & !data_pend_wr);
      wr_busy = data_pend & data_pend_wr;
      e_dok = data_sram_req & (data_sram_wr ? (!wr_busy & !(data_pend & !data_pend_wr)) : (!rd_busy & !wr_busy));
      e_iok = inst_sram_req & !rd_busy & !(data_sram_req & !data_sram_wr);
      e_arv = rd_busy & !ar_done;
      e_awv = wr_busy & !aw_got;
      e_wv  = wr_busy & !w_got;
      r_fire = r_active;
      b_fire = b_active;
      ar_hs = e_arv & arready;
      aw_hs = e_awv & awready;
      w_hs  = e_wv & wready;
      chk("inst_addr_ok", inst_sram_addr_ok, e_iok);
      chk("data_addr_ok", data_sram_addr_ok, e_dok);
      chk("arvalid", arvalid, e_arv);
      chk("awvalid", awvalid, e_awv);
      chk("wvalid", wvalid, e_wv);
      chk("inst_data_ok", inst_sram_data_ok, r_fire & inst_pend);
      chk("data_data_ok", data_sram_data_ok, (r_fire & !inst_pend) | b_fire);
      if (r_fire) chk("rready", rready, 1);
      if (b_fire) chk("bready", bready, 1);
      if (r_fire & inst_pend) chk("inst_rdata", inst_sram_rdata, mem_val(ip_addr));
      if (r_fire & !inst_pend) chk("data_rdata", data_sram_rdata, mem_val(dp_addr));
      if (e_arv) begin
        chk("araddr", araddr, inst_pend ? ip_addr : dp_addr);
        chk("arid", arid, inst_pend ? 0 : 1);
        chk("arsize", arsize, {1'b0, inst_pend ? ip_size : dp_size});
      end
      if (e_awv) begin
        chk("awaddr", awaddr, dp_addr);
        chk("awsize", awsize, {1'b0, dp_size});
      end
      if (e_wv) begin
        chk("wdata", wdata, dp_wdata);
        chk("wstrb", wstrb, dp_wstrb);
      end
      @(posedge clk); #1;
      if (r_fire) begin
        if (inst_pend) inst_pend = 0; else data_pend = 0;
        ar_done = 0; r_active = 0;
      end
      if (b_fire) begin
        data_pend = 0; aw_got = 0; w_got = 0; b_active = 0;
      end
      if (ar_hs) begin ar_done = 1; r_wait = $urandom_range(0, 3); end
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if ((aw_hs | w_hs) & aw_got & w_got) b_wait = $urandom_range(0, 3);
      if (ar_done & !r_active) begin
        if (r_wait == 0) r_active = 1; else r_wait--;
      end
      if (aw_got & w_got & !b_active) begin
        if (b_wait == 0) b_active = 1; else b_wait--;
      end
      if (e_iok) begin
        inst_pend = 1; ip_addr = inst_sram_addr; ip_size = inst_sram_size;
      end
      if (e_dok) begin
        data_pend = 1; data_pend_wr = data_sram_wr; dp_addr = data_sram_addr;
        dp_size = data_sram_size; dp_wdata = data_sram_wdata; dp_wstrb = data_sram_wstrb;
      end
      rvalid = r_active;
      rid    = r_active ? (inst_pend ? 4'd0 : 4'd1) : 4'($urandom);
      rdata  = r_active ? mem_val(inst_pend ? ip_addr : dp_addr) : $urandom;
      rresp  = 2'($urandom);
      bvalid = b_active;
      bid    = 4'd1;
      bresp  = 2'($urandom);
      arready = $urandom_range(0, 2) != 0;
      awready = $urandom_range(0, 2) != 0;
      wready  = $urandom_range(0, 2) != 0;
      if (!inst_sram_req || e_iok) new_inst();
      if (!data_sram_req || e_dok) new_data();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Arbitrating bridge between the core's two SRAM-like ports (instruction fetch, data load/store) and a single AXI3 master port. Sits between the pipeline stages and the top-level AXI interface and serializes the instruction and data requests onto one AR, one AW/W and shared R/B channels. Ordering is in-order per requester. At most one read and one write are outstanding at any time.

## Interface
Parameters: none; all constants come from the shared package.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, asynchronous, active-low
- `inst_sram_req`  in  1  fetch request valid
- `inst_sram_wr`  in  1  write flag; always 0 from fetch, ignored
- `inst_sram_size`  in  2  log2 bytes
- `inst_sram_wstrb`  in  4  ignored
- `inst_sram_addr`  in  32  fetch address
- `inst_sram_wdata`  in  32  ignored
- `inst_sram_addr_ok`  out  1  request accepted this cycle
- `inst_sram_data_ok`  out  1  fetch data valid this cycle
- `inst_sram_rdata`  out  32  fetch data
- `data_sram_req`, `data_sram_wr`, `data_sram_size`[2], `data_sram_wstrb`[4], `data_sram_addr`[32], `data_sram_wdata`[32]  in  data request
- `data_sram_addr_ok`, `data_sram_data_ok`  out  1  handshakes for the data port
- `data_sram_rdata`  out  32  load data
- `arid`[4], `araddr`[32], `arlen`[8], `arsize`[3], `arburst`[2], `arlock`[2], `arcache`[4], `arprot`[3], `arvalid`  out; `arready`  in
- `rid`[4], `rdata`[32], `rresp`[2], `rlast`, `rvalid`  in; `rready`  out
- `awid`[4], `awaddr`[32], `awlen`[8], `awsize`[3], `awburst`[2], `awlock`[2], `awcache`[4], `awprot`[3], `awvalid`  out; `awready`  in
- `wid`[4], `wdata`[32], `wstrb`[4], `wlast`, `wvalid`  out; `wready`  in
- `bid`[4], `bresp`[2], `bvalid`  in; `bready`  out

## Operation
Tied outputs: `arlen`=`awlen`=0; `arburst`=`awburst`=2'b01; `lock`/`cache`/`prot`=0; `wid`=`awid`=1; `wlast`=1.

Read FSM states:
- R_IDLE -> R_AR on read accept.
- R_AR drives `arvalid`; -> R_R on `arready`.
- R_R drives `rready`=1; -> R_IDLE on `rvalid`.
- On accept, latch `araddr` = requester addr, `arsize` = {1'b0,size}, `arid` = 0 (inst) or 1 (data).

Write FSM states:
- W_IDLE -> W_REQ on data-write accept. Latch addr, size, wstrb and wdata.
- W_REQ drives `awvalid` and `wvalid` independently. Each drops after its own handshake. -> W_B once both have completed (same or different cycles).
- W_B drives `bready`=1; -> W_IDLE on `bvalid`.

Accept rules (combinational `addr_ok`):
- Data read: `data_sram_req` & !`data_sram_wr` & R_IDLE & W_IDLE. Blocking on W_IDLE resolves RAW hazards.
- Data write: `data_sram_req` & `data_sram_wr` & W_IDLE & no data read outstanding (R_AR/R_R with `arid`=1).
- Inst read: `inst_sram_req` & R_IDLE & !(data read request present this cycle). Data has read priority.
- An inst read and a data write may be accepted in the same cycle.

Responses:
- `inst_sram_data_ok` = `rvalid` & `rready` & `rid`==0.
- `data_sram_data_ok` = (`rvalid` & `rready` & `rid`==1) | (`bvalid` & `bready`).
- `*_rdata` = `rdata`, passed combinationally.
- The accept rules guarantee R and B never complete for the data port in the same cycle.
- `rresp`/`bresp` are ignored.

## Timing
- Reset (async, `resetn`=0): both FSMs idle. `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, all `addr_ok` and all `data_ok` read 0 immediately, without waiting for a clock edge.
- In-flight AXI transactions are abandoned; their late responses after reset are not a bench requirement.
- Accept at cycle T -> `arvalid`/`awvalid` at T+1. Minimum read latency is `data_ok` at T+2, given `arready` at T+1 and `rvalid` at T+2.
- Minimum write latency is `data_ok` at T+2, given both ready at T+1 and `bvalid` at T+2.
- Latched request fields are held stable while the corresponding valid is high.
- Requester inputs may change freely after `addr_ok`.

## Structure
- Shared package `axi_pkg`: ID_INST=4'd0, ID_DATA=4'd1, BURST_INCR=2'b01, and the read/write state encodings.
- Natural sub-module `axi_wr_ctrl`: write FSM plus AW/W/B latches. Read FSM and arbitration stay in the top.

## Test plan
- Inst read of 0x1c000000, arready=1, rvalid 3 cycles later with rdata=0x02800c04 -> addr_ok at T; arvalid/arid=0 at T+1; inst data_ok with 0x02800c04 at T+4.
- Inst and data reads requested in the same cycle -> data addr_ok only, arid=1. Inst accepted the cycle after data's rvalid completes.
- Data write to 0x8000 (wstrb=4'hf), then data read to 0x8000 -> read addr_ok held 0 until bvalid. AR issued only afterward. Two data_ok pulses, in order.
- awready at T+1, wready at T+3 -> awvalid drops at T+2, wvalid held until T+3, bready from T+4. data_ok on bvalid.
- Inst read in R_R concurrent with an accepted data write -> both complete. rid=0 response routes only to inst_sram_data_ok.
- resetn asserted during R_AR -> arvalid and rready read 0 before the next edge. After release, a new inst read is accepted normally.
